// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between the ibus fetch port and the cbus arbiter.
// Encodings: size MSIZE4=2, MSIZE8=3; len = beats-1 (MLEN1=0, MLEN4=3); burst FIXED=0, INCR=1.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        flush,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [2:0]  creq_size,
  output logic [63:0] creq_addr,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  output logic [3:0]  creq_len,
  output logic [1:0]  creq_burst,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [63:0] cresp_data
);
  localparam int IDX  = $clog2(SETS);
  localparam int BW   = $clog2(WORDS);
  localparam int OFS  = BW + 3;
  localparam int TAGW = 64 - OFS - IDX;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REFILL  = 2'd1;
  localparam logic [1:0] S_UNCACHE = 2'd2;

  localparam logic [2:0] MSIZE4      = 3'd2;
  localparam logic [2:0] MSIZE8      = 3'd3;
  localparam logic [3:0] MLEN1       = 4'd0;
  localparam logic [3:0] MLEN_LINE   = 4'(WORDS - 1);
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  logic [1:0]      state;
  logic            flush_pend;
  logic [BW-1:0]   cnt;
  logic [63:0]     lat_addr;
  logic [SETS-1:0] valid;
  logic [TAGW-1:0] tags  [SETS];
  logic [63:0]     lines [SETS][WORDS];

  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic [BW-1:0]   req_beat;
  logic            req_cached;
  logic            hit;
  logic [63:0]     hit_word;
  logic [IDX-1:0]  lat_idx;
  logic [TAGW-1:0] lat_tag;

  assign req_idx    = ireq_addr[OFS+IDX-1:OFS];
  assign req_tag    = ireq_addr[63:OFS+IDX];
  assign req_beat   = ireq_addr[OFS-1:3];
  assign req_cached = ireq_addr[31];
  assign hit        = valid[req_idx] && (tags[req_idx] == req_tag);
  assign hit_word   = lines[req_idx][req_beat];
  assign lat_idx    = lat_addr[OFS+IDX-1:OFS];
  assign lat_tag    = lat_addr[63:OFS+IDX];

  // creq is a pure function of state and the latched address, so it holds steady for the arbiter
  always_comb begin
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'h0;
    creq_valid    = 1'b0;
    creq_is_write = 1'b0;
    creq_size     = 3'h0;
    creq_addr     = 64'h0;
    creq_strobe   = 8'h0;
    creq_data     = 64'h0;
    creq_len      = 4'h0;
    creq_burst    = 2'h0;
    case (state)
      S_IDLE: begin
        if (ireq_valid && req_cached && hit) begin
          iresp_addr_ok = 1'b1;
          iresp_data_ok = 1'b1;
          iresp_data    = ireq_addr[2] ? hit_word[63:32] : hit_word[31:0];
        end
      end
      S_REFILL: begin
        creq_valid = 1'b1;
        creq_size  = MSIZE8;
        creq_addr  = lat_addr;
        creq_len   = MLEN_LINE;
        creq_burst = BURST_INCR;
      end
      S_UNCACHE: begin
        creq_valid = 1'b1;
        creq_size  = MSIZE4;
        creq_addr  = lat_addr;
        creq_len   = MLEN1;
        creq_burst = BURST_FIXED;
        if (cresp_ready) begin
          iresp_addr_ok = 1'b1;
          iresp_data_ok = 1'b1;
          iresp_data    = lat_addr[2] ? cresp_data[63:32] : cresp_data[31:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      flush_pend <= 1'b0;
      cnt        <= '0;
      lat_addr   <= 64'h0;
      valid      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) valid <= '0;
          if (ireq_valid && req_cached && !hit) begin
            lat_addr <= {ireq_addr[63:OFS], {OFS{1'b0}}};
            state    <= S_REFILL;
          end else if (ireq_valid && !req_cached) begin
            lat_addr <= ireq_addr;
            state    <= S_UNCACHE;
          end
        end
        S_REFILL: begin
          if (flush) flush_pend <= 1'b1;
          if (cresp_ready) begin
            cnt <= cnt + 1'b1;
            // last ends the burst regardless of how many beats were counted
            if (cresp_last) begin
              cnt        <= '0;
              state      <= S_IDLE;
              flush_pend <= 1'b0;
              if (flush_pend || flush) valid <= '0;
              else valid[lat_idx] <= 1'b1;
            end
          end
        end
        S_UNCACHE: begin
          if (flush) flush_pend <= 1'b1;
          if (cresp_ready) begin
            state      <= S_IDLE;
            flush_pend <= 1'b0;
            if (flush_pend || flush) valid <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid[] alone decides whether they mean anything
  always_ff @(posedge clk) begin
    if (state == S_REFILL && cresp_ready) begin
      lines[lat_idx][cnt] <= cresp_data;
      if (cresp_last) tags[lat_idx] <= lat_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: a directed fetch table, a randomized run against a line-level cache
// model with a synthetic memory, and hand-written reset-mid-burst and flush sequences.
module tb_icache_direct;
  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        flush;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic [3:0]  creq_len;
  logic [1:0]  creq_burst;
  logic        cresp_ready, cresp_last;
  logic [63:0] cresp_data;

  always #5 clk = ~clk;

  icache_direct dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .flush(flush),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .creq_len(creq_len), .creq_burst(creq_burst),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
  );

  int checks = 0;
  int errors = 0;

  // reference model: which line address each set currently holds
  bit          m_valid [16];
  logic [63:0] m_tag   [16];

  typedef struct {
    logic [63:0] addr;
    int          fcyc;
    int          beats;
    int          lat;
  } vec_t;

  function automatic logic [63:0] mem64(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    if (b == 64'h4000_0000) return 64'h1122_3344_5566_7788;
    return {b[31:0] ^ 32'h5A5A_1234, b[31:0] + 32'h1111_0000};
  endfunction

  function automatic logic [31:0] mem32(input logic [63:0] a);
    logic [63:0] w;
    w = mem64(a);
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_step(input logic [63:0] a, input int fcyc, output int exp_beats);
    int idx;
    bit hit;
    idx = int'(a[8:5]);
    hit = m_valid[idx] && (m_tag[idx] == (a >> 9));
    if (!a[31]) begin
      exp_beats = 1;
      if (fcyc >= 0) model_clear();
    end else if (hit) begin
      exp_beats = 0;
      if (fcyc == 0) model_clear();
    end else begin
      exp_beats = (fcyc >= 1) ? 8 : 4;
      if (fcyc >= 0) model_clear();
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a >> 9;
    end
  endtask

  // Presents one fetch and plays the memory side until data_ok (or the cycle budget runs out).
  task automatic fetch(input logic [63:0] a, input int fcyc, input int gap_pct,
                       output logic [31:0] d, output int lat, output int beats,
                       output int vcyc, output bit fbad, output bit done);
    bit          cached;
    logic [63:0] exp_addr;
    int          bi;
    cached   = a[31];
    exp_addr = cached ? {a[63:5], 5'b0} : a;
    d = 32'h0; lat = 0; beats = 0; vcyc = 0; fbad = 1'b0; done = 1'b0; bi = 0;
    ireq_valid = 1'b1;
    ireq_addr  = a;
    for (int c = 0; c < 100 && !done; c++) begin
      flush       = (c == fcyc);
      cresp_ready = 1'b0;
      cresp_last  = 1'b0;
      cresp_data  = 64'h0;
      if (creq_valid && $urandom_range(99) >= gap_pct) begin
        cresp_ready = 1'b1;
        cresp_data  = mem64(exp_addr + 64'(bi * 8));
        cresp_last  = cached ? (bi == 3) : 1'b1;
      end
      #4;
      if (creq_valid) begin
        vcyc++;
        if (creq_is_write !== 1'b0 || creq_strobe !== 8'h0 || creq_data !== 64'h0 ||
            creq_addr !== exp_addr) fbad = 1'b1;
        if (cached && (creq_size !== 3'd3 || creq_len !== 4'd3 || creq_burst !== 2'd1)) fbad = 1'b1;
        if (!cached && (creq_size !== 3'd2 || creq_len !== 4'd0 || creq_burst !== 2'd0)) fbad = 1'b1;
      end
      if (cresp_ready) begin
        beats++;
        bi = cresp_last ? 0 : bi + 1;
      end
      if (iresp_data_ok) begin
        done = 1'b1;
        d    = iresp_data;
        lat  = c;
        if (iresp_addr_ok !== 1'b1) fbad = 1'b1;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; ireq_valid = 1'b0; cresp_ready = 1'b0; cresp_last = 1'b0;
  endtask

  task automatic exec(input string nm, input logic [63:0] a, input int fcyc, input int gap,
                      input int tbl_beats, input int tbl_lat);
    int          eb, lat, beats, vcyc, evc;
    logic [31:0] d;
    bit          fbad, done;
    model_step(a, fcyc, eb);
    fetch(a, fcyc, gap, d, lat, beats, vcyc, fbad, done);
    if (!done) begin
      chk($sformatf("%s timeout", nm), 64'(done), 64'd1);
    end else begin
      chk($sformatf("%s data @%h", nm, a), 64'(d), 64'(mem32(a)));
      chk($sformatf("%s beats @%h", nm, a), 64'(beats), 64'(eb));
      chk($sformatf("%s creq_fields @%h", nm, a), 64'(fbad), 64'd0);
      evc = (eb == 0) ? 0 : (eb == 1) ? lat : (eb == 8) ? lat - 2 : lat - 1;
      chk($sformatf("%s creq_valid_cycles @%h", nm, a), 64'(vcyc), 64'(evc));
      if (eb == 0) chk($sformatf("%s hit_latency @%h", nm, a), 64'(lat), 64'd0);
      if (tbl_beats >= 0) chk($sformatf("%s tbl_beats @%h", nm, a), 64'(beats), 64'(tbl_beats));
      if (tbl_lat >= 0) chk($sformatf("%s tbl_latency @%h", nm, a), 64'(lat), 64'(tbl_lat));
    end
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b0; ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; flush = 1'b0;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'h0;
    model_clear();
    #3;
    chk("reset data_ok", 64'(iresp_data_ok), 64'd0);
    chk("reset addr_ok", 64'(iresp_addr_ok), 64'd0);
    chk("reset creq_valid", 64'(creq_valid), 64'd0);
    ireq_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    tbl.push_back('{64'h8000_0000,           -1, 4, 5});
    tbl.push_back('{64'h8000_0004,           -1, 0, 0});
    tbl.push_back('{64'h8000_0018,           -1, 0, 0});
    tbl.push_back('{64'h8000_0200,           -1, 4, 5});
    tbl.push_back('{64'h8000_0000,           -1, 4, 5});
    tbl.push_back('{64'h4000_0004,           -1, 1, 1});
    tbl.push_back('{64'h8000_0040,            2, 8, 10});
    tbl.push_back('{64'h8000_0040,           -1, 0, 0});
    tbl.push_back('{64'h8000_0044,            0, 0, 0});
    tbl.push_back('{64'h8000_0040,           -1, 4, 5});
    tbl.push_back('{64'h8000_0000,           -1, 4, 5});
    tbl.push_back('{64'h8000_0008,           -1, 0, 0});
    tbl.push_back('{64'hFFFF_FFFF_8000_001C, -1, 4, 5});
    tbl.push_back('{64'h8000_0000,           -1, 4, 5});
    tbl.push_back('{64'h0000_0010,            1, 1, 1});
    tbl.push_back('{64'h8000_0000,           -1, 4, 5});
    for (int i = 0; i < tbl.size(); i++)
      exec($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].fcyc, 0, tbl[i].beats, tbl[i].lat);

    for (int n = 0; n < 400; n++) begin
      logic [63:0] a;
      int          fc, r;
      if ($urandom_range(99) < 15) begin
        a  = 64'h4000_0000 | 64'($urandom_range(255) << 2);
        r  = $urandom_range(9);
        fc = (r == 0) ? 0 : (r == 1) ? 1 : -1;
      end else begin
        a  = 64'h8000_0000 | 64'($urandom_range(2) << 9) | 64'($urandom_range(15) << 5)
             | 64'($urandom_range(7) << 2);
        r  = $urandom_range(19);
        fc = (r == 0) ? 0 : (r == 1) ? 2 : -1;
      end
      exec("rnd", a, fc, ($urandom_range(1) == 1) ? 30 : 0, -1, -1);
    end

    // flush pulse in IDLE empties the whole cache
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    model_clear();
    exec("post_flush", 64'h8000_0008, -1, 0, 4, 5);

    // reset during the second beat of a refill
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0120;
    @(posedge clk); #1;
    cresp_ready = 1'b1; cresp_last = 1'b0; cresp_data = mem64(64'h8000_0120);
    @(posedge clk); #1;
    cresp_data = mem64(64'h8000_0128);
    chk("pre_reset creq_valid", 64'(creq_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset creq_valid", 64'(creq_valid), 64'd0);
    chk("mid_reset data_ok", 64'(iresp_data_ok), 64'd0);
    cresp_ready = 1'b0; ireq_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    exec("after_reset", 64'h8000_0120, -1, 0, 4, 5);
    exec("after_reset_hit", 64'h8000_0124, -1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule
